// File: rtl/echo_emulator.sv
// echo_emulator -- synthesizable ultrasonic sensor responder.
//
// Watches the ranging core's transmit trigger and answers with a single
// echo pulse delayed by the round-trip flight time for a programmable
// distance. Out-of-range distances produce a no_echo strobe instead.
//
// Ports:
//   system_clk   in   sole clock
//   reset        in   asynchronous, active-low
//   stimulus     in   trigger from ranging core (asynchronous, synchronized here)
//   enable       in   1 = accept new triggers
//   distance_cm  in   simulated target distance, sampled at trigger acceptance
//   cathode      out  echo pulse
//   busy         out  high in every state except IDLE
//   no_echo      out  one-cycle strobe for an accepted out-of-range trigger
//   overrun      out  sticky; trigger edge seen while busy
//   echo_count   out  echo pulses emitted, wraps at 16 bits
module echo_emulator #(
    parameter int CYCLES_PER_CM  = 5882,
    parameter int DIST_W         = 10,
    parameter int MAX_CM         = 400,
    parameter int PULSE_CYCLES   = 10,
    parameter int HOLDOFF_CYCLES = 100000,
    parameter int CNT_W          = 32
) (
    input  logic              system_clk,
    input  logic              reset,
    input  logic              stimulus,
    input  logic              enable,
    input  logic [DIST_W-1:0] distance_cm,
    output logic              cathode,
    output logic              busy,
    output logic              no_echo,
    output logic              overrun,
    output logic [15:0]       echo_count
);

    typedef enum logic [1:0] {IDLE, DELAY, PULSE, HOLDOFF} state_t;

    localparam logic [CNT_W-1:0] CPC      = CNT_W'(CYCLES_PER_CM);
    localparam logic [CNT_W-1:0] MAX_D    = CNT_W'(MAX_CM);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stim_meta, stim_sync, stim_prev;
    logic             edge_det, accept, out_of_range;
    logic [CNT_W-1:0] delay_load;
    logic             cathode_d, busy_d, no_echo_d, overrun_d;
    logic [15:0]      echo_count_d;

    // Two-flop synchronizer plus a history flop for rising-edge detection.
    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            stim_meta <= 1'b0;
            stim_sync <= 1'b0;
            stim_prev <= 1'b0;
        end else begin
            stim_meta <= stimulus;
            stim_sync <= stim_meta;
            stim_prev <= stim_sync;
        end
    end

    assign edge_det     = stim_sync & ~stim_prev;
    assign accept       = edge_det & enable & (state_q == IDLE);
    assign delay_load   = CNT_W'(distance_cm) * CPC;
    assign out_of_range = CNT_W'(distance_cm) > MAX_D;

    // State register. cnt_q is shared: delay countdown, then pulse width,
    // then holdoff length, reloaded on each state entry.
    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. DELAY leaves when the count is about to hit zero so
    // that cathode rises exactly d*CYCLES_PER_CM cycles after DELAY entry;
    // a zero delay skips DELAY altogether.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (out_of_range) begin
                        state_d = HOLDOFF;
                        cnt_d   = HOLD_LD;
                    end else if (delay_load == '0) begin
                        state_d = PULSE;
                        cnt_d   = PULSE_LD;
                    end else begin
                        state_d = DELAY;
                        cnt_d   = delay_load;
                    end
                end
            end
            DELAY: begin
                if (cnt_q == ONE) begin
                    state_d = PULSE;
                    cnt_d   = PULSE_LD;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = HOLDOFF;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            HOLDOFF: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic, computed from the next state so every output comes
    // straight off a flop and tracks the state register cycle for cycle.
    always_comb begin
        cathode_d    = (state_d == PULSE);
        busy_d       = (state_d != IDLE);
        no_echo_d    = accept & out_of_range;
        // An edge coinciding with HOLDOFF->IDLE still sees state_q != IDLE.
        overrun_d    = overrun | (edge_det & (state_q != IDLE));
        echo_count_d = echo_count;
        if ((state_d == PULSE) && (state_q != PULSE))
            echo_count_d = echo_count + 16'd1;
    end

    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            cathode    <= 1'b0;
            busy       <= 1'b0;
            no_echo    <= 1'b0;
            overrun    <= 1'b0;
            echo_count <= '0;
        end else begin
            cathode    <= cathode_d;
            busy       <= busy_d;
            no_echo    <= no_echo_d;
            overrun    <= overrun_d;
            echo_count <= echo_count_d;
        end
    end

endmodule

// File: tb/tb_echo_emulator.sv
// Directed bench for echo_emulator with small timing parameters.
module tb_echo_emulator;

    logic       system_clk = 1'b0;
    logic       reset = 1'b0;
    logic       stimulus = 1'b0;
    logic       enable = 1'b1;
    logic [9:0] distance_cm = '0;
    logic       cathode, busy, no_echo, overrun;
    logic [15:0] echo_count;

    int checks = 0;
    int failures = 0;

    echo_emulator #(
        .CYCLES_PER_CM(4), .DIST_W(10), .MAX_CM(400),
        .PULSE_CYCLES(3), .HOLDOFF_CYCLES(8), .CNT_W(32)
    ) dut (
        .system_clk (system_clk),
        .reset      (reset),
        .stimulus   (stimulus),
        .enable     (enable),
        .distance_cm(distance_cm),
        .cathode    (cathode),
        .busy       (busy),
        .no_echo    (no_echo),
        .overrun    (overrun),
        .echo_count (echo_count)
    );

    always #5 system_clk = ~system_clk;

    int cyc = 0;
    always @(posedge system_clk) cyc <= cyc + 1;

    // Event recorder, sampled on the falling edge.
    int   rises = 0, rise_cyc = -1, fall_cyc = -1;
    int   ne_cnt = 0, ne_cyc = -1, bfall_cyc = -1, busy_cycles = 0;
    logic cath_prev = 1'b0, busy_prev = 1'b0;
    always @(negedge system_clk) begin
        if (cathode && !cath_prev) begin rises = rises + 1; rise_cyc = cyc; end
        if (!cathode && cath_prev) fall_cyc = cyc;
        if (no_echo) begin ne_cnt = ne_cnt + 1; ne_cyc = cyc; end
        if (!busy && busy_prev) bfall_cyc = cyc;
        if (busy) busy_cycles = busy_cycles + 1;
        cath_prev = cathode;
        busy_prev = busy;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge system_clk);
        #1;
    endtask

    // Raise stimulus for len cycles; t_edge is the cycle the edge is detected.
    int t_edge = 0;
    task automatic fire(input int d, input int len);
        distance_cm = d[9:0];
        tick();
        stimulus = 1'b1;
        t_edge = cyc + 2;
        repeat (len) tick();
        stimulus = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        repeat (4) tick();
        for (int i = 0; i < budget && busy; i++) tick();
        chk({tag, " idle"}, 32'(busy), 32'd0);
        repeat (3) tick();
    endtask

    task automatic wait_cath(input string tag, input logic lvl, input int budget);
        for (int i = 0; i < budget && (cathode !== lvl); i++) tick();
        chk(tag, 32'(cathode), 32'(lvl));
    endtask

    int t, r0, n0, b0;

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst cathode", 32'(cathode), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst no_echo", 32'(no_echo), 32'd0);
        chk("rst overrun", 32'(overrun), 32'd0);
        chk("rst count", 32'(echo_count), 32'd0);
        reset = 1'b1;
        repeat (3) tick();

        // 1. Basic echo, d=5 -> 20 cycles of flight
        fire(5, 10); t = t_edge;
        wait_idle("t1", 100);
        chk("t1 rise", rise_cyc, t + 21);
        chk("t1 width", fall_cyc - rise_cyc, 3);
        chk("t1 busy tail", bfall_cyc - fall_cyc, 8);
        chk("t1 rises", rises, 1);
        chk("t1 count", 32'(echo_count), 32'd1);

        // 2. Range boundaries
        fire(0, 4); t = t_edge;
        wait_idle("t2 d0", 50);
        chk("t2 d0 rise", rise_cyc, t + 1);
        chk("t2 d0 count", 32'(echo_count), 32'd2);

        fire(400, 4); t = t_edge;
        wait_idle("t2 d400", 1700);
        chk("t2 d400 rise", rise_cyc, t + 1601);
        chk("t2 d400 count", 32'(echo_count), 32'd3);

        r0 = rises; n0 = ne_cnt;
        fire(401, 4); t = t_edge;
        wait_idle("t2 d401", 50);
        chk("t2 d401 rises", rises, r0);
        chk("t2 d401 no_echo n", ne_cnt, n0 + 1);
        chk("t2 d401 no_echo at", ne_cyc, t + 1);
        chk("t2 d401 count", 32'(echo_count), 32'd3);

        // 3. Overrun: second edge in DELAY, third in HOLDOFF
        r0 = rises;
        fire(5, 4); t = t_edge;
        repeat (2) tick();
        fire(5, 4);
        chk("t3 overrun delay", 32'(overrun), 32'd1);
        wait_cath("t3 wait rise", 1'b1, 40);
        wait_cath("t3 wait fall", 1'b0, 10);
        fire(5, 4);
        wait_idle("t3", 50);
        chk("t3 rise", rise_cyc, t + 21);
        chk("t3 rises", rises, r0 + 1);
        chk("t3 overrun sticky", 32'(overrun), 32'd1);
        chk("t3 count", 32'(echo_count), 32'd4);
        fire(3, 4); t = t_edge;
        wait_idle("t3 after", 50);
        chk("t3 after rise", rise_cyc, t + 13);
        chk("t3 after count", 32'(echo_count), 32'd5);
        chk("t3 after overrun", 32'(overrun), 32'd1);

        // 4. Enable and latching
        reset = 1'b0; tick(); reset = 1'b1; repeat (3) tick();
        enable = 1'b0;
        b0 = busy_cycles; r0 = rises;
        fire(5, 4);
        repeat (30) tick();
        chk("t4 dis busy", busy_cycles, b0);
        chk("t4 dis rises", rises, r0);
        chk("t4 dis overrun", 32'(overrun), 32'd0);
        chk("t4 dis count", 32'(echo_count), 32'd0);
        enable = 1'b1;
        repeat (3) tick();
        fire(5, 4); t = t_edge;
        repeat (5) tick();
        distance_cm = 10'd50;
        enable = 1'b0;
        wait_idle("t4 latch", 100);
        enable = 1'b1;
        chk("t4 latch rise", rise_cyc, t + 21);
        chk("t4 latch count", 32'(echo_count), 32'd1);

        // 5. Reset mid-pulse
        fire(5, 4);
        repeat (2) tick();
        fire(5, 4);
        wait_cath("t5 wait rise", 1'b1, 40);
        chk("t5 pre overrun", 32'(overrun), 32'd1);
        chk("t5 pre count", 32'(echo_count), 32'd2);
        reset = 1'b0;
        #1;
        chk("t5 rst cathode", 32'(cathode), 32'd0);
        chk("t5 rst busy", 32'(busy), 32'd0);
        chk("t5 rst count", 32'(echo_count), 32'd0);
        chk("t5 rst overrun", 32'(overrun), 32'd0);
        tick(); reset = 1'b1; repeat (3) tick();
        fire(2, 4); t = t_edge;
        wait_idle("t5 post", 50);
        chk("t5 post rise", rise_cyc, t + 9);
        chk("t5 post count", 32'(echo_count), 32'd1);

        // 6a. Counter wrap from a preloaded value
        force dut.echo_count = 16'hFFFE;
        tick();
        release dut.echo_count;
        tick();
        fire(0, 4);
        wait_idle("t6 ffff", 50);
        chk("t6 count ffff", 32'(echo_count), 32'hFFFF);
        fire(0, 4);
        wait_idle("t6 wrap", 50);
        chk("t6 count wrap", 32'(echo_count), 32'd0);

        // 6b. Stimulus held high gives one edge only
        r0 = rises;
        fire(1, 200); t = t_edge;
        wait_idle("t6 long", 50);
        chk("t6 long rises", rises, r0 + 1);
        chk("t6 long rise", rise_cyc, t + 5);
        chk("t6 long overrun", 32'(overrun), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
